// File: rtl/stream_window_3.sv
// 3x3 sliding window over a raster pixel stream, built from two line memories
// and a 3x3 shift register; flags windows whose centre lies inside the frame.
module stream_window_3 #(
  parameter int PRECISION = 16,
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [7:0]                        in_pixel,
  input  logic                              in_valid,
  input  logic                              in_sof,
  output logic signed [PRECISION-1:0]       buffer_3 [2:0][2:0],
  output logic                              window_valid,
  output logic [$clog2(WIDTH)-1:0]          center_x,
  output logic [$clog2(HEIGHT)-1:0]         center_y,
  output logic                              frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] pos_x;
  logic [RW-1:0] pos_y;
  logic          last_col;
  logic          last_row;
  logic [7:0]    a1;
  logic [7:0]    a2;

  logic [7:0] line1 [WIDTH];
  logic [7:0] line2 [WIDTH];

  // A start-of-frame pixel is placed at (0,0) whatever the counters say.
  always_comb begin
    pos_x    = in_sof ? '0 : col;
    pos_y    = in_sof ? '0 : row;
    last_col = (pos_x == CW'(WIDTH - 1));
    last_row = (pos_y == RW'(HEIGHT - 1));
    a1       = line1[pos_x];
    a2       = line2[pos_x];
  end

  // Line memories are never cleared; the row>=2 gate keeps stale data out.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      line2[pos_x] <= a1;
      line1[pos_x] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col          <= '0;
      row          <= '0;
      window_valid <= 1'b0;
      center_x     <= '0;
      center_y     <= '0;
      frame_done   <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          buffer_3[r][c] <= '0;
        end
      end
    end else begin
      frame_done <= in_valid && last_col && last_row;
      if (in_valid) begin
        for (int r = 0; r < 3; r++) begin
          buffer_3[r][0] <= buffer_3[r][1];
          buffer_3[r][1] <= buffer_3[r][2];
        end
        buffer_3[0][2] <= PRECISION'(a2);
        buffer_3[1][2] <= PRECISION'(a1);
        buffer_3[2][2] <= PRECISION'(in_pixel);

        window_valid <= (pos_x >= CW'(2)) && (pos_y >= RW'(2));
        if ((pos_x >= CW'(2)) && (pos_y >= RW'(2))) begin
          center_x <= pos_x - CW'(1);
          center_y <= pos_y - RW'(1);
        end

        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : pos_y + RW'(1);
        end else begin
          col <= pos_x + CW'(1);
          row <= pos_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_window_3.sv
// Directed bench for stream_window_3 on a 4x4 frame with pixel = 16*row + col.
module tb_stream_window_3;

  logic               clk;
  logic               reset_n;
  logic [7:0]         in_pixel;
  logic               in_valid;
  logic               in_sof;
  logic signed [15:0] win [2:0][2:0];
  logic               window_valid;
  logic [1:0]         center_x;
  logic [1:0]         center_y;
  logic               frame_done;

  int checks;
  int failures;
  int valid_count;
  int done_count;

  stream_window_3 #(.PRECISION(16), .WIDTH(4), .HEIGHT(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_pixel     (in_pixel),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .buffer_3     (win),
    .window_valid (window_valid),
    .center_x     (center_x),
    .center_y     (center_y),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Presents one pixel for one clock; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic [7:0] pixel, input logic sof);
    in_pixel = pixel;
    in_valid = 1'b1;
    in_sof   = sof;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(16 * r + c);
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    in_pixel = 8'h00;
    in_valid = 1'b0;
    in_sof   = 1'b0;

    #12;
    checkOutput("reset_valid", {31'd0, window_valid}, 32'd0);
    checkOutput("reset_win11", 32'(win[1][1]), 32'd0);
    checkOutput("reset_cx", {30'd0, center_x}, 32'd0);
    checkOutput("reset_done", {31'd0, frame_done}, 32'd0);
    reset_n = 1'b1;

    // First window: pixels 0x00..0x22 without sof.
    for (int k = 0; k < 11; k++) begin
      applyStimulus(pix(k / 4, k % 4), 1'b0);
      checkOutput($sformatf("fill_valid_%0d", k), {31'd0, window_valid}, (k == 10) ? 32'd1 : 32'd0);
    end
    checkOutput("w1_00", 32'(win[0][0]), 32'h00);
    checkOutput("w1_11", 32'(win[1][1]), 32'h11);
    checkOutput("w1_22", 32'(win[2][2]), 32'h22);
    checkOutput("w1_cx", {30'd0, center_x}, 32'd1);
    checkOutput("w1_cy", {30'd0, center_y}, 32'd1);

    applyStimulus(8'h23, 1'b0);
    checkOutput("w2_valid", {31'd0, window_valid}, 32'd1);
    checkOutput("w2_22", 32'(win[2][2]), 32'h23);
    checkOutput("w2_00", 32'(win[0][0]), 32'h01);
    checkOutput("w2_02", 32'(win[0][2]), 32'h03);
    checkOutput("w2_cx", {30'd0, center_x}, 32'd2);
    checkOutput("w2_cy", {30'd0, center_y}, 32'd1);

    // Stall: nothing may move while in_valid is low.
    for (int i = 0; i < 5; i++) begin
      idleCycle();
      checkOutput($sformatf("hold_valid_%0d", i), {31'd0, window_valid}, 32'd1);
      checkOutput($sformatf("hold_22_%0d", i), 32'(win[2][2]), 32'h23);
      checkOutput($sformatf("hold_11_%0d", i), 32'(win[1][1]), 32'h12);
      checkOutput($sformatf("hold_cx_%0d", i), {30'd0, center_x}, 32'd2);
    end

    applyStimulus(8'h30, 1'b0);
    checkOutput("row3_c0_valid", {31'd0, window_valid}, 32'd0);
    applyStimulus(8'h31, 1'b0);
    applyStimulus(8'h32, 1'b0);
    checkOutput("w3_valid", {31'd0, window_valid}, 32'd1);
    checkOutput("w3_00", 32'(win[0][0]), 32'h10);
    checkOutput("w3_11", 32'(win[1][1]), 32'h21);
    checkOutput("w3_cy", {30'd0, center_y}, 32'd2);
    checkOutput("w3_done", {31'd0, frame_done}, 32'd0);
    applyStimulus(8'h33, 1'b0);
    checkOutput("f1_done", {31'd0, frame_done}, 32'd1);
    idleCycle();
    checkOutput("f1_done_drop", {31'd0, frame_done}, 32'd0);

    // Full second frame; counters wrapped to (0,0) on their own.
    valid_count = 0;
    done_count  = 0;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(pix(k / 4, k % 4), 1'b0);
      if (window_valid) valid_count++;
      if (frame_done) done_count++;
      checkOutput($sformatf("f2_valid_%0d", k), {31'd0, window_valid},
                  ((k / 4 >= 2) && (k % 4 >= 2)) ? 32'd1 : 32'd0);
      checkOutput($sformatf("f2_done_%0d", k), {31'd0, frame_done}, (k == 15) ? 32'd1 : 32'd0);
      if ((k / 4 >= 2) && (k % 4 >= 2)) begin
        checkOutput($sformatf("f2_cx_%0d", k), {30'd0, center_x}, 32'(k % 4 - 1));
        checkOutput($sformatf("f2_cy_%0d", k), {30'd0, center_y}, 32'(k / 4 - 1));
        checkOutput($sformatf("f2_11_%0d", k), 32'(win[1][1]), 32'(pix(k / 4 - 1, k % 4 - 1)));
      end
    end
    checkOutput("f2_window_count", 32'(valid_count), 32'd4);
    checkOutput("f2_done_count", 32'(done_count), 32'd1);

    // Aborted frame: six pixels, then sof restarts on the 7th.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(pix(k / 4, k % 4), k == 0);
      checkOutput($sformatf("abort_done_%0d", k), {31'd0, frame_done}, 32'd0);
    end
    done_count = 0;
    for (int n = 0; n < 16; n++) begin
      applyStimulus(pix(n / 4, n % 4), n == 0);
      if (frame_done) done_count++;
      checkOutput($sformatf("sof_valid_%0d", n), {31'd0, window_valid},
                  ((n / 4 >= 2) && (n % 4 >= 2)) ? 32'd1 : 32'd0);
      checkOutput($sformatf("sof_done_%0d", n), {31'd0, frame_done}, (n == 15) ? 32'd1 : 32'd0);
    end
    checkOutput("sof_done_count", 32'(done_count), 32'd1);

    // Asynchronous reset between clock edges with a valid window on the outputs.
    for (int k = 0; k < 11; k++) applyStimulus(pix(k / 4, k % 4), 1'b0);
    checkOutput("pre_rst_valid", {31'd0, window_valid}, 32'd1);
    applyStimulus(8'h23, 1'b0);
    applyStimulus(8'h30, 1'b0);
    applyStimulus(8'h31, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_valid", {31'd0, window_valid}, 32'd0);
    checkOutput("arst_win12", 32'(win[1][2]), 32'd0);
    checkOutput("arst_win22", 32'(win[2][2]), 32'd0);
    checkOutput("arst_cx", {30'd0, center_x}, 32'd0);
    checkOutput("arst_cy", {30'd0, center_y}, 32'd0);
    #4;
    reset_n = 1'b1;

    for (int k = 0; k < 11; k++) begin
      applyStimulus(pix(k / 4, k % 4), 1'b0);
      checkOutput($sformatf("rerun_valid_%0d", k), {31'd0, window_valid}, (k == 10) ? 32'd1 : 32'd0);
    end
    checkOutput("rerun_00", 32'(win[0][0]), 32'h00);
    checkOutput("rerun_11", 32'(win[1][1]), 32'h11);
    checkOutput("rerun_22", 32'(win[2][2]), 32'h22);
    checkOutput("rerun_cx", {30'd0, center_x}, 32'd1);
    checkOutput("rerun_cy", {30'd0, center_y}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_window_3.md
STREAM_WINDOW_3 -- requirements
Module: stream_window_3

Interface
REQ-001 SHALL have parameter PRECISION, default 16, bit width of each window element.
REQ-002 SHALL have parameter WIDTH, default 640, pixels per line.
REQ-003 SHALL have parameter HEIGHT, default 480, lines per frame.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_pixel  input  8  unsigned pixel, raster order.
REQ-007 SHALL have port in_valid  input  1  in_pixel is accepted this cycle.
REQ-008 SHALL have port in_sof  input  1  start of frame; qualified by in_valid; marks the pixel at (0,0).
REQ-009 SHALL have port buffer_3  output  signed PRECISION x [2:0][2:0]  3x3 window. Row index 0 is the oldest line. Column index 0 is the oldest column.
REQ-010 SHALL have port window_valid  output  1  buffer_3 holds a complete in-frame window.
REQ-011 SHALL have port center_x  output  $clog2(WIDTH)  column of the buffer_3[1][1] pixel.
REQ-012 SHALL have port center_y  output  $clog2(HEIGHT)  row of the buffer_3[1][1] pixel.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-014 SHALL keep a column counter col (0..WIDTH-1) and a row counter row (0..HEIGHT-1) giving the position of the next accepted pixel.
REQ-015 SHALL zero-extend in_pixel to PRECISION bits as a non-negative signed value.
REQ-016 SHALL hold two line memories, line1 (row-1) and line2 (row-2), each WIDTH entries of 8 bits, with combinational read at address col.
REQ-017 On an accepted pixel p at (col,row), SHALL read a1=line1[col] and a2=line2[col], then write line2[col]<=a1 and line1[col]<=p in the same cycle.
REQ-018 On an accepted pixel, SHALL shift the window left (buffer_3[r][0]<=[r][1], [r][1]<=[r][2]) and load [0][2]<=a2, [1][2]<=a1, [2][2]<=p.
REQ-019 SHALL hold buffer_3, the counters, the line memories, window_valid, center_x and center_y unchanged on cycles with in_valid=0.
REQ-020 SHALL register window_valid=1 on the cycle after accepting a pixel with col>=2 and row>=2, and 0 after any other accepted pixel; latency is 1 cycle.
REQ-021 When window_valid is set, SHALL register center_x=col-1 and center_y=row-1 of that accepted pixel.
REQ-022 Column wrap: SHALL set col to 0 and increment row when a pixel is accepted at col=WIDTH-1.
REQ-023 Frame wrap: SHALL set col to 0 and row to 0 when a pixel is accepted at (WIDTH-1,HEIGHT-1), and pulse frame_done for exactly 1 cycle on the next cycle.
REQ-024 SHALL treat a pixel accepted with in_sof=1 as position (0,0) regardless of the counters. The next position is (1,0), and window_valid for that pixel is 0.
REQ-025 Early in_sof (frame not complete): SHALL abandon the current frame and not pulse frame_done.
REQ-026 SHALL not clear the line memories on reset or in_sof; stale contents never reach a valid window because of REQ-020.
REQ-027 SHALL produce no output for border pixels (row 0, row HEIGHT-1, col 0, col WIDTH-1 as centers); the window does not wrap across lines.
REQ-028 SHALL provide no backpressure: one pixel per cycle is accepted at full rate.

Reset
REQ-029 While reset_n=0, SHALL set col=0, row=0, all buffer_3 elements=0, window_valid=0, center_x=0, center_y=0 and frame_done=0, independent of clk.
REQ-030 After reset_n deasserts, SHALL treat the first accepted pixel as (0,0) even without in_sof.
REQ-031 Reset mid-frame SHALL discard frame progress; the next valid window requires 2 full lines plus 3 pixels.

Verification (bench uses WIDTH=4, HEIGHT=4, PRECISION=16, pixel=16*row+col)
REQ-032 Cover: reset, then 11 consecutive pixels 0x00..0x22 -> window_valid=1 the cycle after 0x22. buffer_3[0][0]=0x00, [1][1]=0x11, [2][2]=0x22, center=(1,1).
REQ-033 Cover: continue with pixel 0x23 -> window_valid=1, [2][2]=0x23, [0][0]=0x01, center=(2,1). Then pixel 0x30 -> window_valid=0.
REQ-034 Cover: in_valid=0 for 5 cycles mid-frame -> buffer_3, window_valid and center remain constant throughout.
REQ-035 Cover: full 16-pixel frame -> frame_done high exactly 1 cycle after pixel 0x33, with 4 valid windows at centers (1,1),(2,1),(1,2),(2,2).
REQ-036 Cover: in_sof asserted on the 7th pixel of a frame -> no frame_done for the aborted frame. The first valid window appears after 11 pixels counted from the sof pixel.
REQ-037 Cover: reset_n pulsed low asynchronously between edges mid-frame -> outputs zero immediately. Restart from 0x00 reproduces REQ-032.
